// File: rtl/iter_divider_pkg.sv
// Shared constants, state encoding and helpers for the iterative divider.
package iter_divider_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement negate, modulo 2^XLEN.
    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the execute stage and the divider.
interface iter_divider_if;
    import iter_divider_pkg::*;

    logic            i_start_1;
    logic            i_signed_1;
    logic [XLEN-1:0] i_dividend_32;
    logic [XLEN-1:0] i_divisor_32;
    logic            o_busy_1;
    logic            o_done_1;
    logic [XLEN-1:0] o_quotient_32;
    logic [XLEN-1:0] o_remainder_32;

    modport master (
        output i_start_1, i_signed_1, i_dividend_32, i_divisor_32,
        input  o_busy_1, o_done_1, o_quotient_32, o_remainder_32
    );

    modport slave (
        input  i_start_1, i_signed_1, i_dividend_32, i_divisor_32,
        output o_busy_1, o_done_1, o_quotient_32, o_remainder_32
    );

endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
    import iter_divider_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The shifted remainder is below 2*dvs, so the difference always fits
    // a signed XLEN+1 value and its top bit is the borrow.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted + {1'b1, ~dvs} + {{XLEN{1'b0}}, 1'b1};
        if (!trial[XLEN]) begin
            rem_nxt = trial[XLEN-1:0];
        end else begin
            rem_nxt = shifted[XLEN-1:0];
        end
        quo_nxt = {quo[XLEN-2:0], ~trial[XLEN]};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned 32-bit divider, one quotient bit per cycle.
module iter_divider
    import iter_divider_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    iter_divider_if.slave bus
);

    state_t            state, state_nxt;
    logic [XLEN-1:0]   rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sgn_q, dvd_neg_q, dvs_neg_q;
    logic [XLEN-1:0]   quot_q, remd_q;

    logic [XLEN-1:0]   rem_step, quo_step;
    logic              is_div0, is_ovf, dvd_neg_in, dvs_neg_in;
    logic              last_iter;

    div_step u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .dvs     (dvs_q),
        .rem_nxt (rem_step),
        .quo_nxt (quo_step)
    );

    // Special-case detection and operand signs straight off the request.
    always_comb begin
        is_div0    = (bus.i_divisor_32 == '0);
        is_ovf     = bus.i_signed_1 && (bus.i_dividend_32 == INT_MIN) &&
                     (bus.i_divisor_32 == {XLEN{1'b1}});
        dvd_neg_in = bus.i_signed_1 && bus.i_dividend_32[XLEN-1];
        dvs_neg_in = bus.i_signed_1 && bus.i_divisor_32[XLEN-1];
        last_iter  = (cnt_q == CNT_W'(XLEN-1));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; special cases skip straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.i_start_1) state_nxt = (is_div0 || is_ovf) ? DONE : RUN;
            RUN:  if (last_iter)     state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up into result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            quot_q    <= '0;
            remd_q    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_start_1) begin
                    sgn_q     <= bus.i_signed_1;
                    dvd_neg_q <= dvd_neg_in;
                    dvs_neg_q <= dvs_neg_in;
                    rem_q     <= '0;
                    cnt_q     <= '0;
                    quo_q     <= dvd_neg_in ? neg(bus.i_dividend_32) : bus.i_dividend_32;
                    dvs_q     <= dvs_neg_in ? neg(bus.i_divisor_32)  : bus.i_divisor_32;
                    if (is_div0) begin
                        quot_q <= DIV0_QUOT;
                        remd_q <= bus.i_dividend_32;
                    end else if (is_ovf) begin
                        quot_q <= INT_MIN;
                        remd_q <= '0;
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    // Remainder follows the dividend sign; negating zero keeps zero.
                    quot_q <= (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? neg(quo_q) : quo_q;
                    remd_q <= (sgn_q && dvd_neg_q) ? neg(rem_q) : rem_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy_1       = (state != IDLE);
    assign bus.o_done_1       = (state == DONE);
    assign bus.o_quotient_32  = quot_q;
    assign bus.o_remainder_32 = remd_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: vector table, random ops, corner sequences.
module tb_iter_divider;
    import iter_divider_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iter_divider_if bus();

    iter_divider dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    vec_t tv[14];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.o_done_1 === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", bus.o_quotient_32, e.q);
                chk("remainder", bus.o_remainder_32, e.r);
            end
        end
    end

    // Drive a start for one cycle; returns at the cycle-1 sample point.
    task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_start_1     = 1'b1;
        bus.i_signed_1    = sg;
        bus.i_dividend_32 = a;
        bus.i_divisor_32  = b;
        @(negedge clk);
        bus.i_start_1 = 1'b0;
    endtask

    // Wait for done with a bounded budget; checks latency and busy coverage.
    task automatic wait_done(input int cyc0, input int lat, input string nm);
        int  cyc;
        bit  busy_ok;
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (bus.o_done_1 !== 1'b1 && cyc < 60) begin
            if (bus.o_busy_1 !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (bus.o_busy_1 !== 1'b1) busy_ok = 1'b0;
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
        chk({nm, "_busy"}, {31'b0, busy_ok}, 32'd1);
        if (cyc >= 60) sb.delete();
        @(negedge clk);
        chk({nm, "_idle_after"}, {31'b0, bus.o_busy_1}, 32'd0);
    endtask

    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input int lat,
                          input string nm);
        exp_t e;
        e.q = q;
        e.r = r;
        sb.push_back(e);
        start_op(sg, a, b);
        wait_done(1, lat, nm);
    endtask

    initial begin
        logic [31:0] a, b, q, r;
        logic        sg;
        int          d0;

        tv[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
        tv[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   34};
        tv[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          34};
        tv[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1};
        tv[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1};
        tv[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1};
        tv[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   34};
        tv[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34};
        tv[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   34};
        tv[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          34};
        tv[10] = '{1'b1, 32'hFFFFFFF8,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF8,   1};
        tv[11] = '{1'b1, 32'd6,          32'hFFFFFFFD,   32'hFFFFFFFE,   32'd0,          34};
        tv[12] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          34};
        tv[13] = '{1'b0, 32'd1,          32'hFFFFFFFF,   32'd0,          32'd1,          34};

        rst               = 1'b1;
        bus.i_start_1     = 1'b0;
        bus.i_signed_1    = 1'b0;
        bus.i_dividend_32 = '0;
        bus.i_divisor_32  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, bus.o_busy_1}, 32'd0);
        chk("reset_done", {31'b0, bus.o_done_1}, 32'd0);
        chk("reset_quot", bus.o_quotient_32, 32'd0);
        chk("reset_rem",  bus.o_remainder_32, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op(tv[i].sg, tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].lat, $sformatf("vec%0d", i));

        // Results stay put while idle.
        repeat (3) @(negedge clk);
        chk("hold_quot", bus.o_quotient_32, 32'd0);
        chk("hold_rem",  bus.o_remainder_32, 32'd1);

        // Random operands against a behavioural model.
        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            sg = 1'($urandom_range(0, 1));
            if (b == 32'd0) b = 32'd3;
            if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
            if (sg) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            run_op(sg, a, b, q, r, 34, $sformatf("rnd%0d", i));
        end

        // A start while busy is ignored, and input changes do not disturb the operation.
        begin
            exp_t e;
            e.q = 32'd14;
            e.r = 32'd2;
            sb.push_back(e);
            start_op(1'b0, 32'd100, 32'd7);
            repeat (9) @(negedge clk);
            bus.i_start_1     = 1'b1;
            bus.i_dividend_32 = 32'd9;
            bus.i_divisor_32  = 32'd3;
            @(negedge clk);
            bus.i_start_1 = 1'b0;
            wait_done(11, 34, "busy_start");
        end

        // Reset mid-operation aborts with no done pulse.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, bus.o_busy_1}, 32'd0);
        chk("abort_done", {31'b0, bus.o_done_1}, 32'd0);
        chk("abort_quot", bus.o_quotient_32, 32'd0);
        chk("abort_rem",  bus.o_remainder_32, 32'd0);
        rst = 1'b0;
        d0  = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, "post_reset");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle 32-bit integer divider, the inverse of the datapath's carry-lookahead add path.
- Produces quotient and remainder using restoring shift-subtract, one quotient bit per cycle.
- Sits beside the ALU in the execute stage. The core stalls on o_busy_1 and captures the result on o_done_1.
- Signed and unsigned operation. Divide-by-zero and overflow results follow RISC-V M semantics.

Parameters:
- XLEN, 32: operand and result width.
- CNT_W, 6: iteration counter width; must hold XLEN.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start_1  in  1  request. Sampled only when o_busy_1=0.
- i_signed_1  in  1  1 = signed division, 0 = unsigned. Sampled with i_start_1.
- i_dividend_32  in  XLEN  dividend. Sampled with i_start_1.
- i_divisor_32  in  XLEN  divisor. Sampled with i_start_1.
- o_busy_1  out  1  high while state is not IDLE.
- o_done_1  out  1  one-cycle pulse; results valid in that cycle.
- o_quotient_32  out  XLEN  quotient. Held until the next accepted start.
- o_remainder_32  out  XLEN  remainder. Held until the next accepted start.

Behaviour:
- Reset: state=IDLE; o_busy_1=0, o_done_1=0; o_quotient_32=0, o_remainder_32=0; counter=0; all internal registers cleared.
- Reset mid-operation aborts the operation the same edge. No o_done_1 is produced for the aborted operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE with i_start_1=1: latch the operands, the signed flag, and both operand sign bits. The operand sign bits count only when signed.
  - Divisor == 0: next state DONE; quotient = all ones; remainder = dividend, unmodified.
  - Signed, dividend = 0x80000000 and divisor = 0xFFFFFFFF: next state DONE; quotient = 0x80000000; remainder = 0.
  - Otherwise: convert both operands to magnitudes (two's-complement negate if signed and negative); clear the partial remainder; counter = 0; next state RUN.
- RUN, one iteration per cycle:
  - Shift {partial remainder, quotient} left by 1.
  - Trial = shifted remainder − divisor magnitude, computed at XLEN+1 bits.
  - Trial non-negative: remainder = trial, quotient LSB = 1. Otherwise remainder unchanged, quotient LSB = 0.
  - counter increments. After XLEN iterations, next state FIX.
- FIX:
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend was negative.
  - Remainder sign always equals the dividend sign; a zero remainder stays zero.
  - Next state DONE.
- DONE: o_done_1=1 for exactly this cycle; next state IDLE unconditionally. i_start_1 in DONE is ignored.
- Latency, with start sampled in cycle 0:
  - Normal path: RUN in cycles 1–32, FIX in cycle 33, o_done_1 high in cycle 34.
  - Special cases: o_done_1 high in cycle 1.
- i_start_1 while o_busy_1=1 is ignored. In-flight operands are unaffected by input changes.
- Output registers update only on the FIX→DONE transition or the special-case entry into DONE. They are otherwise stable.
- All arithmetic is modulo 2^XLEN. No exceptions are raised.

Decomposition:
- Shared package holds:
  - XLEN.
  - State encoding: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - Constants DIV0_QUOT (all ones) and INT_MIN (0x80000000).
- One sub-module, div_step: a combinational single iteration. Inputs are the partial remainder, quotient and divisor magnitude; outputs are the next remainder and next quotient.
  - The trial subtract is implemented as addition of the inverted divisor with carry-in 1.
  - The top-level FSM instantiates div_step once and owns the counter and the sign fix-up.

Test Plan:
- Unsigned 100 / 7, start in cycle 0 → o_done_1 in cycle 34; quotient 14, remainder 2; o_busy_1 high in cycles 1–34.
- Signed −7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Same inputs unsigned → quotient 0x7FFFFFFC, remainder 1.
- 5 / 0, both modes → o_done_1 in cycle 1; quotient 0xFFFFFFFF, remainder 5.
- Signed 0x80000000 / 0xFFFFFFFF → o_done_1 in cycle 1; quotient 0x80000000, remainder 0. Unsigned → quotient 0, remainder 0x80000000 at cycle 34.
- Start 100/7, then pulse i_start_1 with 9/3 at cycle 10 → 9/3 ignored; cycle-34 result is quotient 14, remainder 2.
- Start 100/7, assert i_rst at cycle 15 → next cycle IDLE, o_busy_1=0, outputs 0, no o_done_1. A fresh 9/3 start afterwards returns quotient 3, remainder 0 after 34 cycles.
